// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32I main control FSM (optional ILLEGAL_OP_TRAP_EN)
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [1:0]         imm_src,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t state_q, state_next;
  logic   pc_update, branch, ir_write_c, mem_write_c, reg_write_c;

  // only funct3[0] distinguishes beq/bne
  wire unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next  = state_q;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_update  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BRANCH:    state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // enables forced low combinationally while reset is held, so an abort leaves no partial write
  assign pc_write  = rst_n & (pc_update | (branch & (zero ^ funct3[0])));
  assign ir_write  = rst_n & ir_write_c;
  assign mem_write = rst_n & mem_write_c;
  assign reg_write = rst_n & reg_write_c;
  assign state     = state_q;

  always_comb begin
    case (op)
      OP_SW:     imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op = (state_q == S_TRAP);
`endif

endmodule
